// File: rtl/fp_unpack_normalizer.sv
// fp_unpack_normalizer: unpacks an IEEE-754 word into sign, unbiased exponent and hidden-bit significand, normalising denormals one shift per cycle
module fp_unpack_normalizer #(
    parameter int EXPONENT_BITS = 8,
    parameter int FRACTION_BITS = 23,
    parameter int BIAS          = 127
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_BITS+FRACTION_BITS:0]   in_float,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_sign,
    output logic [EXPONENT_BITS:0]                 out_exp,
    output logic [FRACTION_BITS:0]                 out_mant,
    output logic                                   out_zero,
    output logic                                   out_denorm,
    output logic                                   out_inf,
    output logic                                   out_nan
);
    localparam int EB = EXPONENT_BITS;
    localparam int FB = FRACTION_BITS;
    localparam logic [EB:0] EXP_BIAS = (EB+1)'(BIAS);
    localparam logic [EB:0] EXP_INF  = (EB+1)'(BIAS + 1);
    localparam logic [EB:0] EXP_DEN  = (EB+1)'(1 - BIAS);
    localparam logic [EB:0] EXP_ONE  = (EB+1)'(1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t state, state_nx;

    logic          sgn;
    logic [EB-1:0] e_f;
    logic [FB-1:0] frac;
    logic          e_zero, e_ones, f_zero, accept;

    assign sgn    = in_float[EB+FB];
    assign e_f    = in_float[FB +: EB];
    assign frac   = in_float[FB-1:0];
    assign e_zero = (e_f == '0);
    assign e_ones = &e_f;
    assign f_zero = (frac == '0);
    assign accept = in_valid && in_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: denormals detour through NORM until the shifted MSB lands on the hidden bit
    always_comb begin
        state_nx = (state == IDLE) ? (in_valid ? ((e_zero && !f_zero) ? NORM : DONE) : IDLE) :
                   (state == NORM) ? (out_mant[FB-1] ? DONE : NORM) :
                                     (out_ready ? IDLE : DONE);
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // result registers: loaded on accept, shifted while normalising, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sign   <= 1'b0;
            out_exp    <= '0;
            out_mant   <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
            out_inf    <= 1'b0;
            out_nan    <= 1'b0;
        end else if (accept) begin
            out_sign   <= sgn;
            out_mant   <= {!(e_zero || e_ones), frac};
            out_exp    <= e_zero ? (f_zero ? '0 : EXP_DEN) : e_ones ? EXP_INF : {1'b0, e_f} - EXP_BIAS;
            out_zero   <= e_zero && f_zero;
            out_denorm <= e_zero && !f_zero;
            out_inf    <= e_ones && f_zero;
            out_nan    <= e_ones && !f_zero;
        end else if (state == NORM) begin
            out_mant   <= {out_mant[FB-1:0], 1'b0};
            out_exp    <= out_exp - EXP_ONE;
        end
    end
endmodule
